// File: rtl/nmi_arbiter.sv
// rtl/nmi_arbiter.sv - two-master round-robin arbiter in front of a shared NMI slave
// Adds a response watchdog that completes a stalled transfer with all-ones data and a sticky flag.
module nmi_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        m0_valid_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_wstrb_i,
    output logic        m0_ready_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_valid_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_wstrb_i,
    output logic        m1_ready_o,
    output logic [31:0] m1_rdata_o,
    output logic        s_valid_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    output logic [3:0]  s_wstrb_o,
    input  logic        s_ready_i,
    input  logic [31:0] s_rdata_i,
    output logic [1:0]  gnt_o,
    output logic        tmo_o,
    input  logic        tmo_clr_i
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;

    logic        busy, sel_valid, tmo_hit, abort, complete, expire, rsp_ready;
    logic [31:0] sel_addr, sel_wdata, rsp_data;
    logic [3:0]  sel_wstrb;

    always_comb begin
        busy      = (state_q == BUSY);
        sel_valid = gnt_q[1] ? m1_valid_i : m0_valid_i;
        sel_addr  = gnt_q[1] ? m1_addr_i  : m0_addr_i;
        sel_wdata = gnt_q[1] ? m1_wdata_i : m0_wdata_i;
        sel_wstrb = gnt_q[1] ? m1_wstrb_i : m0_wstrb_i;

        // cnt_q is zero in the first BUSY cycle, so the watchdog fires in BUSY cycle TIMEOUT_CYC
        tmo_hit   = busy && ((32'(cnt_q) + 32'd1) == TIMEOUT_CYC);
        abort     = busy && !sel_valid;
        complete  = busy && sel_valid && s_ready_i;
        expire    = busy && sel_valid && !s_ready_i && tmo_hit;
        rsp_ready = complete || expire;
        rsp_data  = expire ? 32'hFFFF_FFFF : s_rdata_i;

        s_valid_o  = busy && sel_valid && !expire;
        s_addr_o   = busy ? sel_addr  : 32'h0;
        s_wdata_o  = busy ? sel_wdata : 32'h0;
        s_wstrb_o  = busy ? sel_wstrb : 4'h0;

        m0_ready_o = rsp_ready && gnt_q[0];
        m0_rdata_o = gnt_q[0] ? rsp_data : 32'h0;
        m1_ready_o = rsp_ready && gnt_q[1];
        m1_rdata_o = gnt_q[1] ? rsp_data : 32'h0;
    end

    assign gnt_o = gnt_q;
    assign tmo_o = tmo_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q && !tmo_clr_i;
        case (state_q)
            IDLE: begin
                cnt_d = 16'h0;
                if (m0_valid_i || m1_valid_i) begin
                    state_d = BUSY;
                    // last_q set means m1 was served last, so m0 takes a tie
                    if (m0_valid_i && m1_valid_i) gnt_d = last_q ? 2'b01 : 2'b10;
                    else                          gnt_d = {m1_valid_i, m0_valid_i};
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 16'd1;
                if (abort) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                end else if (rsp_ready) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    last_d  = gnt_q[1];
                    if (expire) tmo_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= 16'h0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end
endmodule

// File: doc/nmi_arbiter.md
NMI_ARBITER -- requirements
Module: nmi_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, slave-response watchdog limit in cycles (1..65535).
REQ-002 SHALL have port clk_i  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports m0_valid_i/m1_valid_i  input  1 each  master request.
REQ-005 SHALL have ports m0_addr_i/m1_addr_i  input  32 each  master address.
REQ-006 SHALL have ports m0_wdata_i/m1_wdata_i  input  32 each  master write data.
REQ-007 SHALL have ports m0_wstrb_i/m1_wstrb_i  input  4 each  byte strobes (0 = read).
REQ-008 SHALL have ports m0_ready_o/m1_ready_o  output  1 each  transfer-complete to master.
REQ-009 SHALL have ports m0_rdata_o/m1_rdata_o  output  32 each  read data to master.
REQ-010 SHALL have ports s_valid_o, s_addr_o (32), s_wdata_o (32), s_wstrb_o (4)  output  request to shared NMI slave (nmi2apb bridge).
REQ-011 SHALL have ports s_ready_i (1), s_rdata_i (32)  input  slave response.
REQ-012 SHALL have ports gnt_o  output  2  one-hot current grant; tmo_o  output  1  sticky timeout flag; tmo_clr_i  input  1  clears tmo_o.

Function
REQ-013 SHALL implement states IDLE and BUSY.
- IDLE: no slave request; if any m*_valid_i high, latch grant and go to BUSY next edge (one-cycle arbitration latency).
- BUSY: forward the granted master only; return to IDLE when the transfer completes, times out, or is aborted.
REQ-014 SHALL arbitrate round-robin: on simultaneous requests, grant the master not granted most recently; after reset, m0 wins the first tie.
REQ-015 SHALL grant a single requester immediately regardless of round-robin pointer.
REQ-016 SHALL in BUSY drive s_valid_o = granted m_valid_i and s_addr/wdata/wstrb = granted master fields, combinationally.
REQ-017 SHALL drive s_valid_o = 0 and s_addr/wdata/wstrb = 0 in IDLE.
REQ-018 SHALL route s_ready_i and s_rdata_i to the granted master only; non-granted m*_ready_o = 0 and m*_rdata_o = 0.
REQ-019 SHALL complete a transfer on s_valid_o & s_ready_i; update the round-robin pointer to that master; enter IDLE next edge.
REQ-020 SHALL hold the grant for the whole transfer; a new request from the other master never preempts.
REQ-021 SHALL count BUSY cycles with a 16-bit counter cleared on entry to BUSY.
REQ-022 SHALL on counter == TIMEOUT_CYC without s_ready_i: pulse granted m*_ready_o for one cycle with m*_rdata_o = 32'hFFFF_FFFF, force s_valid_o = 0 that cycle, set tmo_o, update pointer, go to IDLE.
REQ-023 SHALL if s_ready_i and timeout coincide, treat as normal completion (slave data, tmo_o unchanged).
REQ-024 SHALL if the granted master drops valid in BUSY before completion, abort: s_valid_o low, no ready pulse, pointer unchanged, return to IDLE.
REQ-025 SHALL clear tmo_o on tmo_clr_i; if set and clear coincide, set wins.
REQ-026 SHALL drive gnt_o = 2'b00 in IDLE, one-hot in BUSY.
REQ-027 SHALL ignore s_ready_i in IDLE.

Reset
REQ-028 SHALL on rst_n_i low asynchronously: state IDLE, gnt_o = 0, pointer = "m1 last" (m0 priority), counter = 0, tmo_o = 0; all outputs 0.
REQ-029 SHALL on reset during BUSY abandon the transfer with no ready pulse to either master.
REQ-030 SHALL resume arbitration on the first rising edge after rst_n_i deasserts.

Verification
REQ-031 Single m0 read addr 0x1000_0000, slave ready after 3 cycles, rdata 0xA5A5_0001 -> gnt_o=01 one cycle after valid, m0_ready_o 1 cycle, m0_rdata_o=0xA5A5_0001, IDLE next cycle.
REQ-032 m0 and m1 request together from reset, slave ready 1 cycle -> grants m0, m1, m0, m1 alternating; no overlap, one IDLE cycle between.
REQ-033 m1 BUSY, m0 asserts mid-transfer -> gnt_o stays 10 until m1 completes, then m0 granted.
REQ-034 TIMEOUT_CYC=8, slave never ready -> m0_ready_o pulse at 8th BUSY cycle, rdata 0xFFFF_FFFF, tmo_o=1; tmo_clr_i -> tmo_o=0.
REQ-035 s_ready_i on the exact timeout cycle -> slave rdata returned, tmo_o stays 0.
REQ-036 rst_n_i low mid-BUSY -> gnt_o=0, s_valid_o=0 immediately, no ready pulse; after release, m0 wins tie.
